// File: rtl/time_display_driver.sv
// Two-digit seven-segment driver for the 0..31 s game timer.
// Scans ones/tens on a multiplexed active-low display. Time and pause are
// captured once per frame so a digit pair never mixes two input values.
// While the captured pause flag is set, the whole display blinks.
module time_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] time_display,
    input  logic       pause,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;
    localparam logic [3:0]    AN_OFF     = 4'b1111;

    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic          digit_sel;    // 0 = ones slot, 1 = tens slot
    logic          blink_phase;  // 1 = display forced dark
    logic [4:0]    snap_time;
    logic          snap_pause;

    logic          slot_tick;
    logic          snap_en;
    logic          pause_nxt;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    // A frame ends on the tick that leaves the tens slot; capture there.
    assign slot_tick = (ref_cnt == REF_LAST);
    assign snap_en   = slot_tick && digit_sel;
    // Pause value that will be in effect after this edge. Clearing the blink
    // state from it (not from the old snapshot) keeps the first slot after a
    // resume from inheriting a dark phase.
    assign pause_nxt = snap_en ? pause : snap_pause;
    assign dp        = 1'b1;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = SEG_OFF;
        endcase
    endfunction

    // Slot timer, digit select and per-frame snapshot of the timer inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt    <= '0;
            digit_sel  <= 1'b0;
            snap_time  <= 5'd0;
            snap_pause <= 1'b0;
        end else begin
            ref_cnt <= slot_tick ? '0 : ref_cnt + 1'b1;
            if (slot_tick) digit_sel <= ~digit_sel;
            if (snap_en) begin
                snap_time  <= time_display;
                snap_pause <= pause;
            end
        end
    end

    // Blink half-period timer; held at visible while not paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!pause_nxt) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (snap_pause) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Binary 0..31 to two BCD digits by range compare (tens is at most 3).
    always_comb begin
        tens = 2'd0;
        ones = snap_time[3:0];
        if (snap_time >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(snap_time - 5'd30);
        end else if (snap_time >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(snap_time - 5'd20);
        end else if (snap_time >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(snap_time - 5'd10);
        end
    end

    // Next anode/segment pattern: ones, tens, leading-zero blank or blink dark.
    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
        if (!blink_phase) begin
            if (!digit_sel) begin
                an_nxt  = 4'b1110;
                seg_nxt = enc(ones);
            end else if (tens != 2'd0) begin
                an_nxt  = 4'b1101;
                seg_nxt = enc({2'b00, tens});
            end
        end
    end

    // Registered pin drive so the pins never glitch on decode paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end
endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver: stimulus pushes per-cycle expected pin
// values into a queue; a monitor pops and compares them by cycle number.
module tb_time_display_driver;
    localparam int RD = 4;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] time_display = 5'd25;
    logic       pause = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t m;

    // Directed vectors; vector i is shown in frame i+1.
    int          vt[16] = '{25, 25, 13, 7, 31, 0, 10, 20, 20, 20, 20, 20, 20, 20, 20, 20};
    logic [15:0] vp     = 16'b0011_1111_1000_0000;

    time_display_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .time_display(time_display), .pause(pause),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            checks++;
            if (m.cyc < cyc) begin
                errors++;
                $display("FAIL %s cyc %0d: sample missed at cyc %0d", m.name, m.cyc, cyc);
            end else if (an !== m.an || seg !== m.seg || dp !== 1'b1) begin
                errors++;
                $display("FAIL %s cyc %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=1",
                         m.name, m.cyc, an, seg, dp, m.an, m.seg);
            end
        end
    end

    // Hand-computed {ones seg, tens anode, tens seg} for the values used.
    function automatic logic [17:0] digits(input int v);
        case (v)
            0:       digits = {7'b1000000, 4'b1111, 7'b1111111};
            7:       digits = {7'b1111000, 4'b1111, 7'b1111111};
            10:      digits = {7'b1000000, 4'b1101, 7'b1111001};
            13:      digits = {7'b0110000, 4'b1101, 7'b1111001};
            20:      digits = {7'b1000000, 4'b1101, 7'b0100100};
            25:      digits = {7'b0010010, 4'b1101, 7'b0100100};
            31:      digits = {7'b1111001, 4'b1101, 7'b0110000};
            default: digits = '1;
        endcase
    endfunction

    // Cycles (relative to release) that are dark while paused with 20.
    function automatic bit dark(input int off);
        dark = (off >= 81 && off <= 96) || (off >= 113 && off <= 120);
    endfunction

    task automatic push(input int c, input logic [3:0] a, input logic [6:0] s, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.name = nm;
        q.push_back(e);
    endtask

    task automatic push_frame(input int base, input int rel, input logic [17:0] d,
                              input int ncyc, input string nm);
        for (int k = 1; k <= ncyc; k++) begin
            if (dark(base + k - rel))
                push(base + k, 4'b1111, 7'b1111111, {nm, "_dark"});
            else if (k <= RD)
                push(base + k, 4'b1110, d[17:11], {nm, "_ones"});
            else
                push(base + k, d[10:7], d[6:0], {nm, "_tens"});
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int rel;
        int rel2;
        int c0;
        logic [17:0] d;

        // Reset held with a nonzero input: pins stay dark.
        wait_cyc(3);
        for (int c = 4; c <= 6; c++) push(c, 4'b1111, 7'b1111111, "reset");
        wait_cyc(6);
        rel = cyc;
        rst_n = 1'b1;
        push_frame(rel, rel, digits(0), 8, "frame0");

        // Inputs change during the tens slot; the current frame must not tear.
        for (int i = 0; i < 16; i++) begin
            wait_cyc(rel + 8 * i + 5);
            time_display = 5'(vt[i]);
            pause = vp[i];
            d = digits(vt[i]);
            push_frame(rel + 8 * (i + 1), rel, d, (i == 15) ? 5 : 8,
                       $sformatf("v%0d_f%0d", vt[i], i + 1));
        end

        // Async reset in the tens slot, between clock edges.
        wait_cyc(rel + 133);
        #2;
        c0 = cyc;
        push(c0, 4'b1111, 7'b1111111, "async_rst_now");
        rst_n = 1'b0;
        for (int c = c0 + 1; c <= c0 + 3; c++) push(c, 4'b1111, 7'b1111111, "async_rst_hold");
        wait_cyc(c0 + 3);
        rel2 = cyc;
        rst_n = 1'b1;
        push_frame(rel2, rel2, digits(0), 8, "rst_frame0");
        push_frame(rel2 + 8, rel2, digits(20), 8, "rst_frame1");

        for (int k = 0; k < 40 && q.size() > 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
